// File: rtl/div_arb_pkg.sv
// ---------------------------------------------------------------------------
// div_arb_pkg
// Shared types and defaults for the divider arbiter slice.
//   DIV_W        default operand/quotient width of the shared divider
//   DIV_TIMEOUT  default watchdog limit in WAIT cycles
//   arb_state_e  transaction FSM states
//   res_flags_t  status flags returned with each result
// ---------------------------------------------------------------------------
package div_arb_pkg;

  localparam int DIV_W       = 10;
  localparam int DIV_TIMEOUT = 31;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic dvz;
    logic ovf;
    logic tmo;
  } res_flags_t;

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans the request vector starting at
// ptr and wrapping modulo NREQ; the first active request wins.
// Ports:
//   req       in   NREQ   request levels
//   ptr       in   PW     highest-priority requester index
//   pick      out  NREQ   one-hot winner (all zero when no request)
//   pick_idx  out  PW     binary index of the winner
// The pointer register itself lives in the parent.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx
);

  // Rotating priority scan; found stops later candidates from overriding
  // the first hit after the pointer.
  always_comb begin
    int  idx;
    logic found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// ---------------------------------------------------------------------------
// divider_arbiter
// Shares one sequential divider among NREQ requesters. A round-robin pick
// in IDLE captures the winner's operands, then the divider is cleared,
// started, and its first terminal flag is returned to the winner.
// Optional feature macro: DIV_ARB_TIMEOUT_EN adds a WAIT watchdog that
// aborts after TIMEOUT cycles and reports resp_tmo.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req                   per-requester request levels
//   req_a, req_b          packed dividends / divisors, [i*W +: W]
//   gnt                   one-hot pulse when operands are captured
//   resp_valid            one-hot pulse when the result is returned
//   resp_q                quotient (0 on dvz/ovf/tmo)
//   resp_dvz/ovf/tmo      status flags, 0 outside resp_valid
//   div_a, div_b          operands to the divider, stable capture..RESP
//   div_start, div_sclr   divider start pulse and synchronous clear
//   div_q, div_dvz, div_ovf, div_busy, div_valid   divider results/status
// ---------------------------------------------------------------------------
module divider_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = DIV_W,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_q,
  output logic              resp_dvz,
  output logic              resp_ovf,
  output logic              resp_tmo,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  output logic              div_start,
  output logic              div_sclr,
  input  logic [W-1:0]      div_q,
  input  logic              div_dvz,
  input  logic              div_ovf,
  input  logic              div_busy,
  input  logic              div_valid
);

  localparam int PW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [W-1:0]    resp_q_q, resp_q_d;
  res_flags_t      flags_q, flags_d;
  logic [W-1:0]    div_a_q, div_a_d;
  logic [W-1:0]    div_b_q, div_b_d;
  logic            div_start_q, div_start_d;
  logic            div_sclr_q, div_sclr_d;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic            done;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req      (req),
    .ptr      (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign done = div_valid | div_dvz | div_ovf;

  // Next-state and next-output logic. Pulsed outputs default to 0 so they
  // last exactly one cycle; operands hold until the next capture.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    gnt_d        = '0;
    resp_valid_d = '0;
    resp_q_d     = '0;
    flags_d      = '0;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_start_d  = 1'b0;
    div_sclr_d   = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d      = pick;
          owner_d    = pick;
          div_a_d    = req_a[int'(pick_idx)*W +: W];
          div_b_d    = req_b[int'(pick_idx)*W +: W];
          div_sclr_d = 1'b1;
          state_d    = CLEAR;
          if (int'(pick_idx) == NREQ - 1) rr_ptr_d = '0;
          else                            rr_ptr_d = pick_idx + PW'(1);
        end
      end
      CLEAR: begin
        div_start_d = 1'b1;
        state_d     = START;
      end
      START: begin
        state_d = WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
`ifdef DIV_ARB_TIMEOUT_EN
        // cnt_q == TIMEOUT marks the abort cycle in which div_sclr is high;
        // the divider is being cleared, so any flag seen now is ignored.
        if (cnt_q == CW'(TIMEOUT)) begin
          resp_valid_d = owner_q;
          flags_d.tmo  = 1'b1;
          state_d      = RESP;
        end else if (done) begin
          resp_valid_d = owner_q;
          resp_q_d     = (div_dvz || div_ovf) ? '0 : div_q;
          flags_d.dvz  = div_dvz;
          flags_d.ovf  = div_ovf;
          state_d      = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          div_sclr_d = 1'b1;
          cnt_d      = CW'(TIMEOUT);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        if (done) begin
          resp_valid_d = owner_q;
          resp_q_d     = (div_dvz || div_ovf) ? '0 : div_q;
          flags_d.dvz  = div_dvz;
          flags_d.ovf  = div_ovf;
          state_d      = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs are registered here. Reset leaves div_sclr high
  // so the divider is held clear until the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_q_q     <= '0;
      flags_q      <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_start_q  <= 1'b0;
      div_sclr_q   <= 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_q_q     <= resp_q_d;
      flags_q      <= flags_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_start_q  <= div_start_d;
      div_sclr_q   <= div_sclr_d;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_q     = resp_q_q;
  assign resp_dvz   = flags_q.dvz;
  assign resp_ovf   = flags_q.ovf;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_start  = div_start_q;
  assign div_sclr   = div_sclr_q;

  // Completion is signalled by the terminal flags; busy is not needed.
  logic unused_div_busy;
  assign unused_div_busy = div_busy;

`ifdef DIV_ARB_TIMEOUT_EN
  assign resp_tmo = flags_q.tmo;
`else
  assign resp_tmo = 1'b0;
  logic        unused_tmo_flag;
  logic [31:0] unused_timeout;
  assign unused_tmo_flag = flags_q.tmo;
  assign unused_timeout  = 32'(TIMEOUT);
`endif

endmodule
